// File: rtl/comb_pkg.sv
// Shared constants and FSM state type for the combination Wishbone slave.
package comb_pkg;

  localparam logic [7:0] REG_ID      = 8'h00;
  localparam logic [7:0] REG_WIN_LO  = 8'h01;
  localparam logic [7:0] REG_WIN_HI  = 8'h02;
  localparam logic [7:0] REG_FILTER  = 8'h03;
  localparam logic [7:0] REG_SEL     = 8'h04;
  localparam logic [7:0] REG_CAPTURE = 8'h05;
  localparam logic [7:0] REG_START   = 8'h06;
  localparam logic [7:0] REG_RESET   = 8'h07;
  localparam logic [7:0] REG_LUT     = 8'h08;
  localparam logic [7:0] REG_STATUS  = 8'h09;
  localparam logic [7:0] REG_RESULT  = 8'h0F;

  localparam logic [31:0] COMB_ID  = 32'h636F6D62;
  localparam logic [1:0]  LUT_WR   = 2'b10;
  localparam logic [1:0]  LUT_RD   = 2'b01;
  localparam logic [1:0]  LUT_IDLE = 2'b00;
  localparam logic [1:0]  SEL_HIST = 2'b10;
  localparam logic [1:0]  SEL_FIFO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LUT_WAIT,
    ST_RES_WAIT,
    ST_ACK
  } state_t;

endpackage

// File: rtl/combination_wb_slave_if.sv
// Wishbone classic slave-side signal bundle for the combination register slave.
interface combination_wb_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/combination_wb_slave.sv
// Wishbone register slave driving the combination core: config, LUT port and result pops.
// Optional watchdog on LUT/result waits is enabled with COMB_WB_TIMEOUT_EN.
module combination_wb_slave
  import comb_pkg::*;
#(
  parameter int unsigned CHANNELS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned CW            = $clog2(CHANNELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  combination_wb_slave_if.slave wb,
  output logic [63:0]           window,
  output logic [CW-1:0]         filter_min,
  output logic [CW-1:0]         filter_max,
  output logic [1:0]            select_comb_fifo,
  output logic                  capture_enable,
  output logic                  start_reading,
  output logic                  reset_comb,
  input  logic                  reset_comb_done,
  output logic [1:0]            lut_WrRd,
  output logic [13:0]           lut_addr,
  output logic [CHANNELS:0]     lut_dat_i,
  input  logic [CHANNELS:0]     lut_dat_o,
  input  logic                  lut_ack,
  output logic                  ready_i,
  input  logic                  comb_out_vd,
  input  logic [32:0]           comb_count,
  input  logic                  ready_o
);

  state_t      state;
  logic        req_c;
  logic        timeout_sticky;
  logic [31:0] rd_data_c;
  logic [31:0] lut_rd_word_c;
  logic [31:0] result_word_c;
  logic        unused_lut_bits;

  assign req_c         = wb.wb_cyc_i & wb.wb_stb_i;
  assign lut_rd_word_c = {16'h0, lut_dat_o[CHANNELS], 15'(lut_dat_o[CW-2:0])};
  assign result_word_c = comb_count[32] ? 32'hFFFF_FFFF : comb_count[31:0];
  assign unused_lut_bits = ^lut_dat_o[CHANNELS-1:CW-1];

`ifdef COMB_WB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_sticky = 1'b0;
`endif

  // Register read mux for single-cycle accesses
  always_comb begin
    rd_data_c = '0;
    case (wb.wb_adr_i)
      REG_ID:      rd_data_c = COMB_ID;
      REG_WIN_LO:  rd_data_c = window[31:0];
      REG_WIN_HI:  rd_data_c = window[63:32];
      REG_FILTER:  rd_data_c = {16'(filter_max), 16'(filter_min)};
      REG_SEL:     rd_data_c = 32'(select_comb_fifo);
      REG_CAPTURE: rd_data_c = 32'(capture_enable);
      REG_START:   rd_data_c = 32'(start_reading);
      REG_RESET:   rd_data_c = 32'(reset_comb);
      REG_STATUS:  rd_data_c = {30'd0, timeout_sticky, ready_o};
      default:     rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      wb.wb_ack_o      <= 1'b0;
      wb.wb_dat_o      <= '0;
      window           <= '0;
      filter_min       <= '0;
      filter_max       <= CW'(CHANNELS);
      select_comb_fifo <= SEL_HIST;
      capture_enable   <= 1'b0;
      start_reading    <= 1'b0;
      reset_comb       <= 1'b0;
      lut_WrRd         <= LUT_IDLE;
      lut_addr         <= '0;
      lut_dat_i        <= '0;
      ready_i          <= 1'b0;
`ifdef COMB_WB_TIMEOUT_EN
      timeout_sticky   <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
      if (reset_comb && reset_comb_done) reset_comb <= 1'b0;

      case (state)
        ST_IDLE: if (req_c) begin
          // Default path acks next cycle; LUT/result accesses override below
          state       <= ST_ACK;
          wb.wb_ack_o <= 1'b1;
          wb.wb_dat_o <= rd_data_c;
          if (wb.wb_we_i) begin
            case (wb.wb_adr_i)
              REG_WIN_LO:  window[31:0]     <= wb.wb_dat_i;
              REG_WIN_HI:  window[63:32]    <= wb.wb_dat_i;
              REG_FILTER: begin
                filter_min <= wb.wb_dat_i[CW-1:0];
                filter_max <= wb.wb_dat_i[16 +: CW];
              end
              REG_SEL:     select_comb_fifo <= wb.wb_dat_i[1:0];
              REG_CAPTURE: capture_enable   <= wb.wb_dat_i[0];
              REG_START:   start_reading    <= wb.wb_dat_i[0];
              REG_RESET:   reset_comb       <= wb.wb_dat_i[0];
              REG_LUT: begin
                lut_addr <= wb.wb_dat_i[29:16];
                if (wb.wb_dat_i[31:30] == LUT_WR) begin
                  lut_WrRd              <= LUT_WR;
                  lut_dat_i             <= '0;
                  lut_dat_i[CHANNELS]   <= wb.wb_dat_i[15];
                  lut_dat_i[CW-2:0]     <= wb.wb_dat_i[CW-2:0];
                  state                 <= ST_LUT_WAIT;
                  wb.wb_ack_o           <= 1'b0;
                end
              end
`ifdef COMB_WB_TIMEOUT_EN
              REG_STATUS:  timeout_sticky   <= 1'b0;
`endif
              default: ;
            endcase
          end else begin
            case (wb.wb_adr_i)
              REG_LUT: begin
                lut_WrRd    <= LUT_RD;
                state       <= ST_LUT_WAIT;
                wb.wb_ack_o <= 1'b0;
              end
              REG_RESULT: if (start_reading) begin
                ready_i     <= 1'b1;
                state       <= ST_RES_WAIT;
                wb.wb_ack_o <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        ST_LUT_WAIT: if (lut_ack) begin
          if (lut_WrRd == LUT_RD) wb.wb_dat_o <= lut_rd_word_c;
          lut_WrRd    <= LUT_IDLE;
          wb.wb_ack_o <= 1'b1;
          state       <= ST_ACK;
        end

        ST_RES_WAIT: if (ready_i && comb_out_vd) begin
          wb.wb_dat_o <= result_word_c;
          ready_i     <= 1'b0;
          wb.wb_ack_o <= 1'b1;
          state       <= ST_ACK;
        end

        ST_ACK: begin
          wb.wb_ack_o <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

`ifdef COMB_WB_TIMEOUT_EN
      // Watchdog: abandon a stalled LUT or result wait with an all-ones ack
      if (state == ST_IDLE) begin
        wait_cnt <= '0;
      end else if ((state == ST_LUT_WAIT && !lut_ack) ||
                   (state == ST_RES_WAIT && !(ready_i && comb_out_vd))) begin
        if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          lut_WrRd       <= LUT_IDLE;
          ready_i        <= 1'b0;
          wb.wb_dat_o    <= 32'hFFFF_FFFF;
          wb.wb_ack_o    <= 1'b1;
          timeout_sticky <= 1'b1;
          state          <= ST_ACK;
        end else begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_combination_wb_slave.sv
// Directed self-checking bench for combination_wb_slave with LUT and result-core responders.
// Define COMB_WB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_combination_wb_slave;
  import comb_pkg::*;

  localparam int unsigned CH = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned TO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  combination_wb_slave_if wb();

  logic [63:0]   window;
  logic [CW-1:0] filter_min, filter_max;
  logic [1:0]    select_comb_fifo;
  logic          capture_enable, start_reading, reset_comb;
  logic          reset_comb_done = 1'b0;
  logic [1:0]    lut_WrRd;
  logic [13:0]   lut_addr;
  logic [CH:0]   lut_dat_i;
  logic [CH:0]   lut_dat_o = '0;
  logic          lut_ack = 1'b0;
  logic          ready_i;
  logic          comb_out_vd = 1'b0;
  logic [32:0]   comb_count = '0;
  logic          ready_o = 1'b1;

  combination_wb_slave #(.CHANNELS(CH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .wb(wb),
    .window(window), .filter_min(filter_min), .filter_max(filter_max),
    .select_comb_fifo(select_comb_fifo), .capture_enable(capture_enable),
    .start_reading(start_reading), .reset_comb(reset_comb),
    .reset_comb_done(reset_comb_done), .lut_WrRd(lut_WrRd), .lut_addr(lut_addr),
    .lut_dat_i(lut_dat_i), .lut_dat_o(lut_dat_o), .lut_ack(lut_ack),
    .ready_i(ready_i), .comb_out_vd(comb_out_vd), .comb_count(comb_count),
    .ready_o(ready_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bus results of the most recent access
  logic [31:0] rdat;
  int          acks;
  int          lat;

  // LUT responder state
  logic [CH:0] lut_mem [0:15];
  int          lut_cnt = 0;
  int          lut_reqs = 0;
  bit          lut_changed = 0;
  logic [1:0]  cap_wrrd;
  logic [13:0] cap_addr;
  logic [CH:0] cap_dat;

  // Result core state
  logic [32:0] res_q[$];
  int          core_dly = 0;
  logic        xfer = 1'b0;
  bit          rd_pending = 0;
  int          ready_bad = 0;

  initial for (int i = 0; i < 16; i++) lut_mem[i] = '0;

  // LUT responder: acks 7 cycles after a request appears
  always @(negedge clk) begin
    if (lut_ack) begin
      lut_ack = 1'b0;
      lut_cnt = 0;
    end else if (lut_WrRd != 2'b00) begin
      if (lut_cnt == 0) begin
        cap_wrrd = lut_WrRd; cap_addr = lut_addr; cap_dat = lut_dat_i;
        lut_reqs++;
      end else if (lut_WrRd !== cap_wrrd || lut_addr !== cap_addr || lut_dat_i !== cap_dat) begin
        lut_changed = 1;
      end
      lut_cnt++;
      if (lut_cnt == 7) begin
        lut_ack = 1'b1;
        if (lut_WrRd == LUT_WR) lut_mem[lut_addr[3:0]] = lut_dat_i;
        else lut_dat_o = lut_mem[lut_addr[3:0]];
      end
    end else begin
      lut_cnt = 0;
    end
  end

  // Result core: presents queued results after a short delay, holds until transferred
  always @(posedge clk) xfer <= ready_i & comb_out_vd;
  always @(negedge clk) begin
    if (xfer) begin
      comb_out_vd = 1'b0;
      if (res_q.size() > 0) void'(res_q.pop_front());
      core_dly = 0;
    end else if (!comb_out_vd && res_q.size() > 0) begin
      core_dly++;
      if (core_dly == 5) begin
        comb_count  = res_q[0];
        comb_out_vd = 1'b1;
      end
    end
    if (ready_i && !rd_pending) ready_bad++;
  end

  task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat);
    bit got;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;
    got = 0; acks = 0; lat = 0; rdat = '0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(posedge clk); #1;
      lat = i + 1;
      if (wb.wb_ack_o) begin got = 1; rdat = wb.wb_dat_o; end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    if (got) begin
      acks = 1;
      repeat (2) begin @(posedge clk); #1; if (wb.wb_ack_o) acks++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat got=%h exp=0", wb.wb_dat_o); end
    n_checks++; if (window !== 64'h0) begin n_fail++; $display("FAIL rst_window got=%h exp=0", window); end
    n_checks++; if (filter_min !== 5'd0 || filter_max !== 5'd16) begin n_fail++; $display("FAIL rst_filter got=%0d/%0d exp=0/16", filter_min, filter_max); end
    n_checks++; if (select_comb_fifo !== 2'b10) begin n_fail++; $display("FAIL rst_sel got=%b exp=10", select_comb_fifo); end
    n_checks++; if ({capture_enable, start_reading, reset_comb, ready_i} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=0000", {capture_enable, start_reading, reset_comb, ready_i}); end
    n_checks++; if (lut_WrRd !== 2'b00 || lut_addr !== 14'd0 || lut_dat_i !== 17'd0) begin n_fail++; $display("FAIL rst_lut got=%b/%0d/%h exp=0", lut_WrRd, lut_addr, lut_dat_i); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_id_regs();
    bus(1'b0, REG_ID, '0);
    n_checks++; if (rdat !== 32'h636F6D62 || acks !== 1) begin n_fail++; $display("FAIL id got=%h acks=%0d exp=636f6d62 acks=1", rdat, acks); end
    bus(1'b0, REG_FILTER, '0);
    n_checks++; if (rdat !== 32'h0010_0000 || acks !== 1) begin n_fail++; $display("FAIL filter_rst got=%h acks=%0d exp=00100000", rdat, acks); end
    bus(1'b0, REG_SEL, '0);
    n_checks++; if (rdat !== 32'd2 || acks !== 1) begin n_fail++; $display("FAIL sel_rst got=%h acks=%0d exp=2", rdat, acks); end
    bus(1'b0, REG_STATUS, '0);
    n_checks++; if (rdat !== 32'd1) begin n_fail++; $display("FAIL status got=%h exp=1", rdat); end
    // ID is read-only, unmapped addresses read 0 and still ack
    bus(1'b1, REG_ID, 32'h1234_5678);
    bus(1'b0, REG_ID, '0);
    n_checks++; if (rdat !== 32'h636F6D62) begin n_fail++; $display("FAIL id_ro got=%h exp=636f6d62", rdat); end
    bus(1'b1, 8'h20, 32'hDEAD_BEEF);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL unmapped_wr acks=%0d exp=1", acks); end
    bus(1'b0, 8'h20, '0);
    n_checks++; if (rdat !== 32'h0 || acks !== 1) begin n_fail++; $display("FAIL unmapped_rd got=%h acks=%0d exp=0", rdat, acks); end
  endtask

  task automatic test_config();
    bus(1'b1, REG_WIN_LO, 32'h32);
    n_checks++; if (acks !== 1 || lat !== 1) begin n_fail++; $display("FAIL win_lo_ack acks=%0d lat=%0d exp=1/1", acks, lat); end
    bus(1'b1, REG_WIN_HI, 32'h0);
    n_checks++; if (window !== 64'h32) begin n_fail++; $display("FAIL window got=%h exp=32", window); end
    bus(1'b0, REG_WIN_LO, '0);
    n_checks++; if (rdat !== 32'h32 || acks !== 1) begin n_fail++; $display("FAIL win_lo_rd got=%h acks=%0d exp=32", rdat, acks); end
    bus(1'b1, REG_WIN_HI, 32'hDEAD_BEEF);
    n_checks++; if (window !== 64'hDEAD_BEEF_0000_0032) begin n_fail++; $display("FAIL window_hi got=%h exp=deadbeef00000032", window); end
    bus(1'b1, REG_FILTER, {16'd12, 16'd3});
    n_checks++; if (filter_min !== 5'd3 || filter_max !== 5'd12) begin n_fail++; $display("FAIL filter_wr got=%0d/%0d exp=3/12", filter_min, filter_max); end
    bus(1'b0, REG_FILTER, '0);
    n_checks++; if (rdat !== 32'h000C_0003) begin n_fail++; $display("FAIL filter_rd got=%h exp=000c0003", rdat); end
    bus(1'b1, REG_SEL, 32'd1);
    bus(1'b1, REG_CAPTURE, 32'd1);
    n_checks++; if (select_comb_fifo !== 2'b01 || capture_enable !== 1'b1) begin n_fail++; $display("FAIL sel_cap got=%b/%b exp=01/1", select_comb_fifo, capture_enable); end
  endtask

  task automatic test_lut();
    int reqs0;
    bus(1'b1, REG_LUT, {2'b10, 14'd5, 16'h8004});
    n_checks++; if (cap_wrrd !== 2'b10 || cap_addr !== 14'd5) begin n_fail++; $display("FAIL lut_wr_req got=%b/%0d exp=10/5", cap_wrrd, cap_addr); end
    n_checks++; if (cap_dat[16] !== 1'b1 || cap_dat[3:0] !== 4'd4 || lut_changed) begin n_fail++; $display("FAIL lut_wr_dat got=%h changed=%0d exp=10004/0", cap_dat, lut_changed); end
    n_checks++; if (acks !== 1 || lut_WrRd !== 2'b00) begin n_fail++; $display("FAIL lut_wr_done acks=%0d wrrd=%b exp=1/00", acks, lut_WrRd); end
    reqs0 = lut_reqs;
    bus(1'b1, REG_LUT, {2'b00, 14'd5, 16'h0000});
    n_checks++; if (lut_reqs !== reqs0 || lat !== 1) begin n_fail++; $display("FAIL lut_latch reqs=%0d lat=%0d exp=%0d/1", lut_reqs, lat, reqs0); end
    bus(1'b0, REG_LUT, '0);
    n_checks++; if (rdat !== 32'h0000_8004 || acks !== 1) begin n_fail++; $display("FAIL lut_rd got=%h acks=%0d exp=00008004", rdat, acks); end
    bus(1'b1, REG_LUT, {2'b10, 14'd3, 16'h0007});
    bus(1'b0, REG_LUT, '0);
    n_checks++; if (rdat !== 32'h0000_0007 || lut_addr !== 14'd3) begin n_fail++; $display("FAIL lut_rd3 got=%h addr=%0d exp=00000007/3", rdat, lut_addr); end
  endtask

  task automatic test_result_pop();
    bus(1'b0, REG_RESULT, '0);
    n_checks++; if (rdat !== 32'h0 || lat !== 1 || acks !== 1) begin n_fail++; $display("FAIL pop_idle got=%h lat=%0d exp=0/1", rdat, lat); end
    bus(1'b1, REG_START, 32'd1);
    res_q.push_back(33'h1_0000_0005);
    res_q.push_back(33'd7);
    rd_pending = 1;
    bus(1'b0, REG_RESULT, '0);
    rd_pending = 0;
    n_checks++; if (rdat !== 32'hFFFF_FFFF || acks !== 1) begin n_fail++; $display("FAIL pop_sat got=%h acks=%0d exp=ffffffff", rdat, acks); end
    repeat (3) @(posedge clk);
    rd_pending = 1;
    bus(1'b0, REG_RESULT, '0);
    rd_pending = 0;
    n_checks++; if (rdat !== 32'd7 || acks !== 1) begin n_fail++; $display("FAIL pop_7 got=%h acks=%0d exp=7", rdat, acks); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready_bad !== 0 || ready_i !== 1'b0 || res_q.size() !== 0) begin n_fail++; $display("FAIL pop_ready bad=%0d ready=%b left=%0d exp=0/0/0", ready_bad, ready_i, res_q.size()); end
  endtask

  task automatic test_reset_comb();
    bus(1'b1, REG_RESET, 32'd1);
    n_checks++; if (reset_comb !== 1'b1) begin n_fail++; $display("FAIL rcomb_set got=%b exp=1", reset_comb); end
    repeat (10) @(negedge clk);
    n_checks++; if (reset_comb !== 1'b1) begin n_fail++; $display("FAIL rcomb_hold got=%b exp=1", reset_comb); end
    reset_comb_done = 1'b1;
    @(negedge clk);
    reset_comb_done = 1'b0;
    n_checks++; if (reset_comb !== 1'b0) begin n_fail++; $display("FAIL rcomb_clr got=%b exp=0", reset_comb); end
    bus(1'b0, REG_RESET, '0);
    n_checks++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL rcomb_rd got=%h exp=0", rdat); end
    bus(1'b1, REG_RESET, 32'd1);
    bus(1'b1, REG_RESET, 32'd0);
    n_checks++; if (reset_comb !== 1'b0) begin n_fail++; $display("FAIL rcomb_wr0 got=%b exp=0", reset_comb); end
  endtask

`ifdef COMB_WB_TIMEOUT_EN
  task automatic test_timeout();
    bus(1'b1, REG_START, 32'd1);
    rd_pending = 1;
    bus(1'b0, REG_RESULT, '0);
    rd_pending = 0;
    // one edge to enter the wait, then TO cycles waiting before the ack
    n_checks++; if (rdat !== 32'hFFFF_FFFF || acks !== 1 || lat !== TO + 1) begin n_fail++; $display("FAIL timeout got=%h acks=%0d lat=%0d exp=ffffffff/1/%0d", rdat, acks, lat, TO + 1); end
    bus(1'b0, REG_STATUS, '0);
    n_checks++; if (rdat !== 32'd3) begin n_fail++; $display("FAIL timeout_status got=%h exp=3", rdat); end
    bus(1'b1, REG_STATUS, 32'd0);
    bus(1'b0, REG_STATUS, '0);
    n_checks++; if (rdat !== 32'd1) begin n_fail++; $display("FAIL timeout_clear got=%h exp=1", rdat); end
  endtask
`endif

  task automatic test_rst_mid();
    bit saw_ack;
    bus(1'b1, REG_START, 32'd1);
    saw_ack = 0;
    rd_pending = 1;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = REG_RESULT;
    repeat (5) begin @(posedge clk); #1; if (wb.wb_ack_o) saw_ack = 1; end
    n_checks++; if (ready_i !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", ready_i); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    rd_pending = 0;
    repeat (3) begin @(posedge clk); #1; if (wb.wb_ack_o) saw_ack = 1; end
    n_checks++; if (saw_ack) begin n_fail++; $display("FAIL mid_ack got=1 exp=0"); end
    n_checks++; if (ready_i !== 1'b0 || start_reading !== 1'b0 || window !== 64'h0 || filter_max !== 5'd16 || select_comb_fifo !== 2'b10) begin n_fail++; $display("FAIL mid_outs ready=%b start=%b win=%h fmax=%0d sel=%b", ready_i, start_reading, window, filter_max, select_comb_fifo); end
    bus(1'b0, REG_ID, '0);
    n_checks++; if (rdat !== 32'h636F6D62 || acks !== 1) begin n_fail++; $display("FAIL mid_retry got=%h acks=%0d exp=636f6d62", rdat, acks); end
  endtask

  initial begin
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
    test_reset();
    test_id_regs();
    test_config();
    test_lut();
    test_result_pop();
    test_reset_comb();
`ifdef COMB_WB_TIMEOUT_EN
    test_timeout();
`endif
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
